// File: rtl/neuron_sequencer_if.sv
// Stream, weight-port and neuron-side signals of neuron_sequencer bundled as one interface.
// eval_cnt is present only when NEURON_SEQ_PERF_EN is defined.
interface neuron_sequencer_if #(
    parameter int N  = 18,
    parameter int AW = 3
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                w_wr_en;
    logic [AW-1:0]       w_wr_addr;
    logic signed [N-1:0] w_wr_data;
    logic signed [N-1:0] mac_w;
    logic signed [N-1:0] mac_x;
    logic                mac_en;
    logic                mac_clr;
    logic signed [N-1:0] act_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;
    logic                busy;
`ifdef NEURON_SEQ_PERF_EN
    logic [15:0]         eval_cnt;
`endif

    modport slave (
        input  in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, act_in, out_ready,
`ifdef NEURON_SEQ_PERF_EN
        output eval_cnt,
`endif
        output in_ready, mac_w, mac_x, mac_en, mac_clr, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, act_in, out_ready,
`ifdef NEURON_SEQ_PERF_EN
        input  eval_cnt,
`endif
        input  in_ready, mac_w, mac_x, mac_en, mac_clr, out_valid, out_data, busy
    );
endinterface

// File: rtl/neuron_sequencer.sv
// Feeds K buffered (weight, input) pairs into a MAC/ReLU neuron and returns its activation.
// Define NEURON_SEQ_PERF_EN to add the 16-bit eval_cnt handshake counter.
module neuron_sequencer #(
    parameter int N  = 18,
    parameter int K  = 8,
    parameter int AW = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst,
    neuron_sequencer_if.slave bus
);
    typedef enum logic [2:0] {LOAD, CLR, RUN, SETTLE, OUT} state_t;

    localparam logic [AW-1:0] LAST = AW'(K - 1);

    state_t              state;
    logic [AW-1:0]       index;
    logic signed [N-1:0] xbuf [K];
    logic signed [N-1:0] wmem [K];
    logic                w_ok;

    // Addresses beyond K-1 are only reachable when K is not a power of two.
    assign w_ok = bus.w_wr_en && (int'(bus.w_wr_addr) < K);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LOAD;
            index         <= '0;
            bus.in_ready  <= 1'b1;
            bus.mac_en    <= 1'b0;
            bus.mac_clr   <= 1'b0;
            bus.mac_w     <= '0;
            bus.mac_x     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
`ifdef NEURON_SEQ_PERF_EN
            bus.eval_cnt  <= '0;
`endif
            for (int i = 0; i < K; i++) begin
                xbuf[i] <= '0;
                wmem[i] <= '0;
            end
        end else begin
            if (state == LOAD && w_ok)
                wmem[bus.w_wr_addr] <= bus.w_wr_data;

            case (state)
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        xbuf[index] <= bus.in_data;
                        if (index == LAST) begin
                            index        <= '0;
                            bus.in_ready <= 1'b0;
                            bus.mac_clr  <= 1'b1;
                            bus.busy     <= 1'b1;
                            state        <= CLR;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                // mac_w/mac_x are registered, so each pair is fetched one cycle ahead
                CLR: begin
                    bus.mac_clr <= 1'b0;
                    bus.mac_en  <= 1'b1;
                    bus.mac_w   <= wmem[0];
                    bus.mac_x   <= xbuf[0];
                    state       <= RUN;
                end
                RUN: begin
                    if (index == LAST) begin
                        index      <= '0;
                        bus.mac_en <= 1'b0;
                        bus.mac_w  <= '0;
                        bus.mac_x  <= '0;
                        state      <= SETTLE;
                    end else begin
                        index     <= index + 1'b1;
                        bus.mac_w <= wmem[index + 1'b1];
                        bus.mac_x <= xbuf[index + 1'b1];
                    end
                end
                SETTLE: begin
                    bus.out_data  <= bus.act_in;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
`ifdef NEURON_SEQ_PERF_EN
                        bus.eval_cnt  <= bus.eval_cnt + 16'd1;
`endif
                        state         <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
